// File: rtl/wb_load_unit.sv
`default_nettype none
// ============================================================================
// Module   : wb_load_unit
// Purpose  : MIPS write-back stage that buffers in-order MEM instructions,
//            waits for decoupled load responses and aligns load data.
//            Optional debug ports are enabled by defining WB_DEBUG_EN.
// Revision : 1.0
// ============================================================================
module wb_load_unit #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid_in,
    output logic             wb_allowin_out,
    input  logic [31:0]      mem_pc_in,
    input  logic [4:0]       mem_wnum_in,
    input  logic [2:0]       mem_ld_op_in,
    input  logic [1:0]       mem_adrl_in,
    input  logic [31:0]      mem_alu_res_in,
    input  logic             mem_rf_we_in,
    input  logic             flush_in,
    input  logic             data_ok_in,
    input  logic [31:0]      rdata_in,
    output logic             wb_valid_out,
    output logic [3:0]       wb_reg_we_out,
    output logic [4:0]       wb_wnum_out,
    output logic [31:0]      wb_wdata_out,
    output logic [31:0]      wb_pc_out,
`ifdef WB_DEBUG_EN
    output logic [31:0]      debug_wb_pc,
    output logic [3:0]       debug_wb_rf_wen,
    output logic [4:0]       debug_wb_rf_wnum,
    output logic [31:0]      debug_wb_rf_wdata,
`endif
    output logic [CNT_W-1:0] pending_cnt_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] c_op_none = 3'd0;
    localparam logic [2:0] c_op_lb   = 3'd1;
    localparam logic [2:0] c_op_lbu  = 3'd2;
    localparam logic [2:0] c_op_lh   = 3'd3;
    localparam logic [2:0] c_op_lhu  = 3'd4;
    localparam logic [2:0] c_op_lwl  = 3'd6;
    localparam logic [2:0] c_op_lwr  = 3'd7;

    // Entry payload (no reset needed: has_data_q/count_q qualify every read)
    logic [31:0]      pc_q   [DEPTH];
    logic [4:0]       wnum_q [DEPTH];
    logic [2:0]       op_q   [DEPTH];
    logic [1:0]       adrl_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic             rfwe_q [DEPTH];
    logic [DEPTH-1:0] has_data_q;

    logic [PTR_W-1:0] rptr_q, wptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic             ready_q;

    logic             wb_valid_q;
    logic [3:0]       wb_we_q;
    logic [4:0]       wb_wnum_q;
    logic [31:0]      wb_wdata_q;
    logic [31:0]      wb_pc_q;

    logic             w_fill_hit;
    logic [PTR_W-1:0] w_fill_idx;
    logic [CNT_W-1:0] w_unanswered;
    logic [PTR_W:0]   w_slot;
    logic             w_resp_drop, w_resp_fill;
    logic             w_pop, w_push;
    logic [CNT_W:0]   w_occ;

    logic [31:0]      w_head_data, w_shr, w_wdata;
    logic [2:0]       w_head_op;
    logic [1:0]       w_head_adrl;
    logic [15:0]      w_half;
    logic [3:0]       w_we;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // Oldest unanswered load and the number of unanswered loads in the FIFO
    always_comb begin
        w_fill_hit   = 1'b0;
        w_fill_idx   = '0;
        w_unanswered = '0;
        w_slot       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot = {1'b0, rptr_q} + (PTR_W + 1)'(i);
            if (w_slot >= (PTR_W + 1)'(DEPTH)) w_slot = w_slot - (PTR_W + 1)'(DEPTH);
            if ((CNT_W'(i) < count_q) && !has_data_q[w_slot[PTR_W-1:0]]) begin
                w_unanswered = w_unanswered + CNT_W'(1);
                if (!w_fill_hit) begin
                    w_fill_hit = 1'b1;
                    w_fill_idx = w_slot[PTR_W-1:0];
                end
            end
        end
    end

    assign w_resp_drop    = data_ok_in && (discard_q != '0);
    assign w_resp_fill    = data_ok_in && !w_resp_drop && w_fill_hit;
    assign w_pop          = (count_q != '0) && has_data_q[rptr_q] && !flush_in;
    assign w_occ          = {1'b0, count_q} + {1'b0, discard_q};
    assign wb_allowin_out = ready_q && ((w_occ < (CNT_W + 1)'(DEPTH)) || w_pop);
    assign w_push         = mem_valid_in && wb_allowin_out && !flush_in;

    always_comb begin
        count_d   = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        discard_d = discard_q - CNT_W'(w_resp_drop);
        if (flush_in) begin
            count_d   = '0;
            discard_d = discard_d + w_unanswered - CNT_W'(w_resp_fill);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            discard_q  <= '0;
            has_data_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            ready_q   <= 1'b1;
            count_q   <= count_d;
            discard_q <= discard_d;
            if (flush_in) begin
                rptr_q     <= '0;
                wptr_q     <= '0;
                has_data_q <= '0;
            end else begin
                if (w_push) wptr_q <= ptr_inc(wptr_q);
                if (w_pop) rptr_q <= ptr_inc(rptr_q);
                if (w_resp_fill) has_data_q[w_fill_idx] <= 1'b1;
                if (w_push) has_data_q[wptr_q] <= (mem_ld_op_in == c_op_none);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            pc_q[wptr_q]   <= mem_pc_in;
            wnum_q[wptr_q] <= mem_wnum_in;
            op_q[wptr_q]   <= mem_ld_op_in;
            adrl_q[wptr_q] <= mem_adrl_in;
            rfwe_q[wptr_q] <= mem_rf_we_in;
            data_q[wptr_q] <= mem_alu_res_in;
        end
        if (w_resp_fill) data_q[w_fill_idx] <= rdata_in;
    end

    assign w_head_data = data_q[rptr_q];
    assign w_head_op   = op_q[rptr_q];
    assign w_head_adrl = adrl_q[rptr_q];
    assign w_shr       = w_head_data >> {w_head_adrl, 3'b000};
    assign w_half      = w_head_adrl[1] ? w_head_data[31:16] : w_head_data[15:0];

    always_comb begin
        w_we    = 4'hF;
        w_wdata = w_head_data;
        case (w_head_op)
            c_op_none: w_we    = {4{rfwe_q[rptr_q]}};
            c_op_lb:   w_wdata = {{24{w_shr[7]}}, w_shr[7:0]};
            c_op_lbu:  w_wdata = {24'h0, w_shr[7:0]};
            c_op_lh:   w_wdata = {{16{w_half[15]}}, w_half};
            c_op_lhu:  w_wdata = {16'h0, w_half};
            c_op_lwl: begin
                w_wdata = w_head_data << {~w_head_adrl, 3'b000};
                w_we    = 4'hF << ~w_head_adrl;
            end
            c_op_lwr: begin
                w_wdata = w_shr;
                w_we    = 4'hF >> w_head_adrl;
            end
            default: ;
        endcase
    end

    // Retire registers: pc/wnum/wdata hold between retires, valid/we clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= '0;
            wb_wnum_q  <= '0;
            wb_wdata_q <= '0;
            wb_pc_q    <= '0;
        end else if (w_pop) begin
            wb_valid_q <= 1'b1;
            wb_we_q    <= w_we;
            wb_wnum_q  <= wnum_q[rptr_q];
            wb_wdata_q <= w_wdata;
            wb_pc_q    <= pc_q[rptr_q];
        end else begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= '0;
        end
    end

    assign wb_valid_out    = wb_valid_q;
    assign wb_reg_we_out   = wb_we_q;
    assign wb_wnum_out     = wb_wnum_q;
    assign wb_wdata_out    = wb_wdata_q;
    assign wb_pc_out       = wb_pc_q;
    assign pending_cnt_out = count_q;

`ifdef WB_DEBUG_EN
    assign debug_wb_pc       = wb_pc_q;
    assign debug_wb_rf_wen   = wb_we_q;
    assign debug_wb_rf_wnum  = wb_wnum_q;
    assign debug_wb_rf_wdata = wb_wdata_q;
`else
    // Debug trace ports are not present in this build.
`endif

endmodule
`default_nettype wire

// File: doc/wb_load_unit.md
Name: wb_load_unit

Overview:
Write-back stage for the MIPS pipeline with decoupled memory responses. It buffers up to DEPTH in-order instructions from MEM and waits for an asynchronous data_ok/rdata response for each load. It aligns the returned load data for LB/LBU/LH/LHU/LW/LWL/LWR and retires one register write per cycle. On flush it drops all buffered entries and discards responses that belong to flushed loads.

Parameters:
DEPTH, 2, number of buffered instructions and the maximum number of outstanding loads (≥1)
CNT_W, $clog2(DEPTH+1), width of the occupancy and discard counters

Ports:
clk  in  1  clock
rst_n  in  1  reset: rst_n, synchronous, active-low; clock clk
mem_valid_in  in  1  MEM presents an instruction
wb_allowin_out  out  1  stage can accept this cycle
mem_pc_in  in  32  instruction PC
mem_wnum_in  in  5  destination register
mem_ld_op_in  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR
mem_adrl_in  in  2  address bits [1:0]
mem_alu_res_in  in  32  result for non-load ops
mem_rf_we_in  in  1  non-load writes the register file
flush_in  in  1  kill all buffered entries
data_ok_in  in  1  one in-order load response
rdata_in  in  32  load response word
wb_valid_out  out  1  retire pulse
wb_reg_we_out  out  4  byte write enables
wb_wnum_out  out  5  destination register
wb_wdata_out  out  32  write data
wb_pc_out  out  32  retired PC
pending_cnt_out  out  CNT_W  buffered entries

Behaviour:
- Reset: FIFO empty; discard counter 0; all outputs 0; wb_allowin_out is 1 from the cycle after reset.
- Entry fields: pc, wnum, op, adrl, alu_res/rdata, has_data. Non-load entries have has_data=1 on write.
- Accept: mem_valid_in && wb_allowin_out && !flush_in.
- wb_allowin_out = (count + discard_cnt < DEPTH) || retiring this cycle.
- Response: if data_ok_in and discard_cnt>0, decrement discard_cnt and drop rdata. Otherwise, write rdata into the oldest load entry with has_data=0. A data_ok with neither condition true is a protocol error and is ignored.
- Retire: when the head has has_data=1, pop it. Outputs are registered, so wb_valid_out is high for exactly the cycle after the pop edge. Otherwise wb_valid_out=0 and wb_reg_we_out=0.
- Latency, non-load accepted into an empty FIFO at edge N: wb_valid_out is high in the cycle after edge N+1.
- Latency, load head answered at edge N: wb_valid_out is high in the cycle after edge N+1. There is no rdata bypass.
- Throughput: one retire per cycle. Push and pop in the same cycle are allowed when full.
- Alignment (b = adrl*8; sign-extend for LB/LH, zero-extend for LBU/LHU):
  - LB/LBU: byte rdata[b+7:b], we 1111.
  - LH/LHU: half at adrl[1], we 1111.
  - LW: rdata, we 1111.
  - LWL: data = rdata << 8*(3-adrl); we = 1000, 1100, 1110, 1111 for adrl 0..3.
  - LWR: data = rdata >> 8*adrl; we = 1111, 0111, 0011, 0001 for adrl 0..3.
  - Non-load: alu_res, we = {4{mem_rf_we_in}}.
- Flush:
  - FIFO is emptied the next cycle.
  - discard_cnt <= discard_cnt + (loads in FIFO with has_data=0) − (1 if data_ok_in was consumed by a flushed load that cycle).
  - A retire scheduled in the flush cycle is suppressed: wb_valid_out=0 next cycle.
  - flush beats accept; the input is dropped.
  - Entries accepted after the flush are answered only after discard_cnt reaches 0.
- Wrap-around: read and write pointers are mod DEPTH. count and discard_cnt are never allowed to exceed DEPTH.

Optional Feature:
WB_DEBUG_EN:
- Defined: adds output ports debug_wb_pc[31:0], debug_wb_rf_wen[3:0], debug_wb_rf_wnum[4:0] and debug_wb_rf_wdata[31:0]. They equal wb_pc_out, wb_reg_we_out, wb_wnum_out and wb_wdata_out respectively.
- debug_wb_rf_wen is 0 whenever wb_valid_out=0.
- Reset value of all debug outputs is 0.
- Not defined: the ports are absent and there is no extra logic.

Test Plan:
- Non-load ADDU, wnum=3, alu_res=0x1234 pushed at edge N -> cycle after N+1: valid=1, we=1111, wdata=0x1234, wnum=3.
- LB adrl=2, rdata=0x0080FF00 -> wdata=0xFFFFFF80, we=1111. Same stimulus as LBU -> wdata=0x00000080.
- LWL adrl=1, rdata=0xAABBCCDD -> wdata=0xCCDD0000, we=1100. LWR adrl=1, same rdata -> wdata=0x00AABBCC, we=0111.
- DEPTH=2: two loads outstanding with no data_ok -> wb_allowin_out=0 and a third instruction is held. Two data_ok pulses -> two retires in order, then allowin=1.
- Two loads outstanding, flush_in -> pending_cnt=0, discard_cnt=2. A new LW is accepted. Three data_ok pulses -> only the third retires (its rdata).
- Flush in the same cycle as a head retire and a data_ok -> no wb_valid_out, discard_cnt = remaining unanswered flushed loads. Reset asserted mid-load -> all outputs 0 and allowin=1 the cycle after release.
